imem_dmem_port_arbiter: RTL

Shares the single 32-bit memory port between the instruction-fetch stage and the MEM-stage load/store unit of the RV32I 5-stage pipeline. It arbitrates requests and sequences each transaction through a request/acknowledge handshake. It raises halt_pipeline while any requester is waiting. It also bounds data-side starvation of fetch and aborts hung transactions with a sticky error.

---
 rtl/imem_dmem_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/imem_dmem_port_arbiter.sv
`timescale 1ns/1ps
// imem_dmem_port_arbiter
//   Shares one 32-bit word-addressed memory port between instruction fetch
//   and the MEM-stage load/store unit. Data wins arbitration unless it has
//   already taken MAX_DATA_BURST grants in a row while fetch was waiting.
//   A transaction with no mem_ack for TIMEOUT_CYCLES busy cycles is aborted.
//   The requester then gets a dummy completion, and the sticky err flag is set.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   if_req/if_addr        fetch request (level) and word address
//   if_data/if_valid      fetched word; single-cycle completion strobe
//   d_req/d_we/d_addr     data request, store flag and word address
//   d_wdata/d_be          store data and byte enables
//   d_rdata/d_valid       load data; single-cycle completion strobe
//   mem_req..mem_be       registered memory request and payload
//   mem_ack/mem_rdata     memory completion strobe and read data
//   halt_pipeline         stall while any requester is still waiting
//   err                   sticky timeout flag
module imem_dmem_port_arbiter #(
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_IW         = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        halt_pipeline,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);
  localparam logic [7:0] TO_MAX    = 8'(TIMEOUT_CYCLES);

  state_t      state_reg, state_next;
  logic [3:0]  streak_reg, streak_next;
  logic [7:0]  timeout_reg, timeout_next;
  logic        mem_req_reg, mem_req_next;
  logic        mem_we_reg, mem_we_next;
  logic [29:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic [3:0]  mem_be_reg, mem_be_next;
  logic        err_reg, err_next;

  logic        if_done, d_done, timed_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      streak_reg    <= '0;
      timeout_reg   <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      streak_reg    <= streak_next;
      timeout_reg   <= timeout_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_be_reg    <= mem_be_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    streak_next    = streak_reg;
    timeout_next   = timeout_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_be_next    = mem_be_reg;
    err_next       = err_reg;
    if_done        = 1'b0;
    d_done         = 1'b0;
    timed_out      = 1'b0;

    case (state_reg)
      IDLE: begin
        // mem_ack is deliberately ignored here.
        timeout_next = '0;
        if (!if_req) begin
          streak_next = '0;
        end
        if (d_req && !(if_req && streak_reg == BURST_MAX)) begin
          state_next     = BUSY_D;
          mem_req_next   = 1'b1;
          mem_we_next    = d_we;
          mem_addr_next  = d_addr;
          mem_wdata_next = d_wdata;
          mem_be_next    = d_we ? d_be : 4'hF;
          // Only grants that made fetch wait count toward the burst limit.
          if (if_req && streak_reg < BURST_MAX) begin
            streak_next = streak_reg + 4'd1;
          end
        end else if (if_req) begin
          state_next     = BUSY_I;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = if_addr;
          mem_wdata_next = '0;
          mem_be_next    = 4'hF;
          streak_next    = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        if (mem_ack || timeout_reg == TO_MAX) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          timeout_next = '0;
          if (!mem_ack) begin
            timed_out = 1'b1;
            err_next  = 1'b1;
          end
          if (state_reg == BUSY_I) begin
            if_done = 1'b1;
          end else begin
            d_done = 1'b1;
          end
        end else begin
          timeout_next = timeout_reg + 8'd1;
        end
      end

      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  // Every output is forced low while reset is held, even before the first edge.
  assign if_valid      = if_done & ~reset;
  assign d_valid       = d_done & ~reset;
  assign if_data       = reset ? 32'd0 : ((if_done && timed_out) ? NOP_IW : mem_rdata);
  assign d_rdata       = (reset || (d_done && timed_out)) ? 32'd0 : mem_rdata;
  assign mem_req       = mem_req_reg & ~reset;
  assign mem_we        = mem_we_reg & ~reset;
  assign mem_addr      = reset ? 30'd0 : mem_addr_reg;
  assign mem_wdata     = reset ? 32'd0 : mem_wdata_reg;
  assign mem_be        = reset ? 4'd0 : mem_be_reg;
  assign err           = err_reg & ~reset;
  assign halt_pipeline = ~reset & ((if_req & ~if_valid) | (d_req & ~d_valid));

endmodule
